// File: rtl/sdio_pkg.sv
// Shared types and constants for the SD/SDIO command-line engine.
package sdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RESP,
        RECV,
        DONE
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_CRC_ERR = 2'b10;

    localparam int unsigned FRAME_LEN = 48;
    localparam int unsigned CRC_BITS  = 40;

    // x^7 + x^3 + 1 with the x^7 term implied by the shift
    localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sdio_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB-first input, synchronous clear back to zero.
module sdio_crc7
    import sdio_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = bit_in ^ crc_q[6];
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (bit_en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sdio_cmd_engine.sv
// SD/SDIO CMD-line engine: serialises 48-bit command frames and captures optional responses.
// Build option: define SDIO_CMD_CRC_CHECK_EN to check response CRC7, direction and end bits.
//
// state     | meaning
// IDLE      | cmd_ready high, waiting for cmd_valid
// SEND      | driving the 48-bit command frame, one bit per sd_clk fall
// WAIT_RESP | line released, waiting for the response start bit (bounded)
// RECV      | shifting in the remaining 47 response bits
// DONE      | result held on resp_* until resp_ready
module sdio_cmd_engine
    import sdio_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned RESP_TIMEOUT = 64
) (
    input  logic        axi_clk,
    input  logic        axi_resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        cmd_resp_en,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_status,
    output logic        sd_clk,
    output logic        sd_cmd_o,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_i
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TO_W  = $clog2(RESP_TIMEOUT + 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sd_clk_q, sd_clk_d;
    logic             div_tc, rise_tick, fall_tick;

    state_t           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [5:0]       resp_index_q, resp_index_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic [1:0]       resp_status_q, resp_status_d;
    logic             sd_cmd_o_q, sd_cmd_o_d;
    logic             sd_cmd_oe_q, sd_cmd_oe_d;
    logic             resp_en_q, resp_en_d;
    logic [39:0]      tx_sr_q, tx_sr_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [37:0]      rx_sr_q, rx_sr_d;

    logic             accept;
    logic [6:0]       tx_crc;

    always_comb begin
        div_tc    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        div_cnt_d = div_tc ? '0 : div_cnt_q + 1'b1;
        sd_clk_d  = div_tc ? ~sd_clk_q : sd_clk_q;
        rise_tick = div_tc & ~sd_clk_q;
        fall_tick = div_tc & sd_clk_q;
    end

    assign accept = cmd_valid & cmd_ready_q;

    sdio_crc7 u_crc_tx (
        .clk    (axi_clk),
        .rst_n  (axi_resetn),
        .clear  (accept),
        .bit_en (fall_tick && (state_q == SEND) && (bit_cnt_q < 6'(CRC_BITS))),
        .bit_in (tx_sr_q[39]),
        .crc    (tx_crc)
    );

`ifdef SDIO_CMD_CRC_CHECK_EN
    logic       rx_dir_q, rx_dir_d;
    logic [6:0] rx_crc_sr_q, rx_crc_sr_d;
    logic [6:0] rx_crc;

    sdio_crc7 u_crc_rx (
        .clk    (axi_clk),
        .rst_n  (axi_resetn),
        .clear  (accept),
        .bit_en (rise_tick && (((state_q == WAIT_RESP) && !sd_cmd_i) ||
                               ((state_q == RECV) && (bit_cnt_q < 6'(CRC_BITS))))),
        .bit_in (sd_cmd_i),
        .crc    (rx_crc)
    );
`endif

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_index_d  = resp_index_q;
        resp_data_d   = resp_data_q;
        resp_status_d = resp_status_q;
        sd_cmd_o_d    = sd_cmd_o_q;
        sd_cmd_oe_d   = sd_cmd_oe_q;
        resp_en_d     = resp_en_q;
        tx_sr_d       = tx_sr_q;
        bit_cnt_d     = bit_cnt_q;
        to_cnt_d      = to_cnt_q;
        rx_sr_d       = rx_sr_q;
`ifdef SDIO_CMD_CRC_CHECK_EN
        rx_dir_d      = rx_dir_q;
        rx_crc_sr_d   = rx_crc_sr_q;
`endif

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    state_d     = SEND;
                    cmd_ready_d = 1'b0;
                    tx_sr_d     = {2'b01, cmd_index, cmd_arg};
                    resp_en_d   = cmd_resp_en;
                    bit_cnt_d   = '0;
                    to_cnt_d    = '0;
                end
            end

            SEND: begin
                if (fall_tick) begin
                    if (bit_cnt_q < 6'(FRAME_LEN)) begin
                        sd_cmd_oe_d = 1'b1;
                        bit_cnt_d   = bit_cnt_q + 1'b1;
                        if (bit_cnt_q < 6'(CRC_BITS)) begin
                            sd_cmd_o_d = tx_sr_q[39];
                            tx_sr_d    = {tx_sr_q[38:0], 1'b0};
                        end else if (bit_cnt_q < 6'(FRAME_LEN - 1)) begin
                            // CRC occupies bits 40..46, so the low 3 bits of the count select it
                            sd_cmd_o_d = tx_crc[3'd6 - bit_cnt_q[2:0]];
                        end else begin
                            sd_cmd_o_d = 1'b1;
                        end
                    end else begin
                        sd_cmd_oe_d = 1'b0;
                        sd_cmd_o_d  = 1'b1;
                        bit_cnt_d   = '0;
                        to_cnt_d    = '0;
                        if (resp_en_q) begin
                            state_d = WAIT_RESP;
                        end else begin
                            state_d       = DONE;
                            resp_valid_d  = 1'b1;
                            resp_status_d = ST_OK;
                            resp_index_d  = '0;
                            resp_data_d   = '0;
                        end
                    end
                end
            end

            WAIT_RESP: begin
                if (rise_tick) begin
                    if (!sd_cmd_i) begin
                        state_d   = RECV;
                        bit_cnt_d = 6'd1;
                    end else if (to_cnt_q >= TO_W'(RESP_TIMEOUT - 1)) begin
                        to_cnt_d      = TO_W'(RESP_TIMEOUT);
                        state_d       = DONE;
                        resp_valid_d  = 1'b1;
                        resp_status_d = ST_TIMEOUT;
                        resp_index_d  = '0;
                        resp_data_d   = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end

            RECV: begin
                if (rise_tick) begin
                    if (bit_cnt_q < 6'(FRAME_LEN - 1)) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if ((bit_cnt_q >= 6'd2) && (bit_cnt_q < 6'(CRC_BITS))) begin
                            rx_sr_d = {rx_sr_q[36:0], sd_cmd_i};
                        end
`ifdef SDIO_CMD_CRC_CHECK_EN
                        if (bit_cnt_q == 6'd1) begin
                            rx_dir_d = sd_cmd_i;
                        end
                        if (bit_cnt_q >= 6'(CRC_BITS)) begin
                            rx_crc_sr_d = {rx_crc_sr_q[5:0], sd_cmd_i};
                        end
`endif
                    end else begin
                        state_d       = DONE;
                        resp_valid_d  = 1'b1;
                        resp_index_d  = rx_sr_q[37:32];
                        resp_data_d   = rx_sr_q[31:0];
`ifdef SDIO_CMD_CRC_CHECK_EN
                        resp_status_d = ((rx_crc_sr_q != rx_crc) || rx_dir_q || !sd_cmd_i)
                                        ? ST_CRC_ERR : ST_OK;
`else
                        resp_status_d = ST_OK;
`endif
                    end
                end
            end

            DONE: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            div_cnt_q     <= '0;
            sd_clk_q      <= 1'b0;
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_index_q  <= '0;
            resp_data_q   <= '0;
            resp_status_q <= ST_OK;
            sd_cmd_o_q    <= 1'b1;
            sd_cmd_oe_q   <= 1'b0;
            resp_en_q     <= 1'b0;
            tx_sr_q       <= '0;
            bit_cnt_q     <= '0;
            to_cnt_q      <= '0;
            rx_sr_q       <= '0;
`ifdef SDIO_CMD_CRC_CHECK_EN
            rx_dir_q      <= 1'b0;
            rx_crc_sr_q   <= '0;
`endif
        end else begin
            div_cnt_q     <= div_cnt_d;
            sd_clk_q      <= sd_clk_d;
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_index_q  <= resp_index_d;
            resp_data_q   <= resp_data_d;
            resp_status_q <= resp_status_d;
            sd_cmd_o_q    <= sd_cmd_o_d;
            sd_cmd_oe_q   <= sd_cmd_oe_d;
            resp_en_q     <= resp_en_d;
            tx_sr_q       <= tx_sr_d;
            bit_cnt_q     <= bit_cnt_d;
            to_cnt_q      <= to_cnt_d;
            rx_sr_q       <= rx_sr_d;
`ifdef SDIO_CMD_CRC_CHECK_EN
            rx_dir_q      <= rx_dir_d;
            rx_crc_sr_q   <= rx_crc_sr_d;
`endif
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_index  = resp_index_q;
    assign resp_data   = resp_data_q;
    assign resp_status = resp_status_q;
    assign sd_clk      = sd_clk_q;
    assign sd_cmd_o    = sd_cmd_o_q;
    assign sd_cmd_oe   = sd_cmd_oe_q;

endmodule

// File: tb/tb_sdio_cmd_engine.sv
// Self-checking bench for sdio_cmd_engine: fixed SD command vectors plus randomized commands/responses.
module tb_sdio_cmd_engine;

    logic        axi_clk = 1'b0;
    logic        axi_resetn = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        cmd_resp_en = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [5:0]  resp_index;
    logic [31:0] resp_data;
    logic [1:0]  resp_status;
    logic        sd_clk;
    logic        sd_cmd_o;
    logic        sd_cmd_oe;
    logic        sd_cmd_i = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    sdio_cmd_engine dut (
        .axi_clk     (axi_clk),
        .axi_resetn  (axi_resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .cmd_resp_en (cmd_resp_en),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_index  (resp_index),
        .resp_data   (resp_data),
        .resp_status (resp_status),
        .sd_clk      (sd_clk),
        .sd_cmd_o    (sd_cmd_o),
        .sd_cmd_oe   (sd_cmd_oe),
        .sd_cmd_i    (sd_cmd_i)
    );

    always #5 axi_clk = ~axi_clk;

    // CRC7 as the remainder of polynomial long division of M(x)*x^7 by 0x89
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] v;
        v = {d, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        end
        return v[6:0];
    endfunction

    function automatic logic [47:0] mk_frame(input logic dir, input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] head;
        head = {1'b0, dir, idx, arg};
        return {head, crc7_ref(head), 1'b1};
    endfunction

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic resp_en,
                          input logic card_on, input int delay, input logic [47:0] card_frame,
                          output logic [47:0] tx, output logic started, output logic rel_ok,
                          output logic got, output logic [1:0] st, output logic [5:0] ri,
                          output logic [31:0] rd, output int rises);
        logic prev;
        tx = '0; started = 1'b0; rel_ok = 1'b0; got = 1'b0;
        st = '0; ri = '0; rd = '0; rises = 0;
        for (int i = 0; i < 100 && !cmd_ready; i++) begin
            @(posedge axi_clk); #1;
        end
        cmd_index = idx; cmd_arg = arg; cmd_resp_en = resp_en; cmd_valid = 1'b1;
        @(posedge axi_clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge axi_clk); #1;
            if (sd_cmd_oe) begin started = 1'b1; break; end
        end
        if (!started) return;
        for (int b = 0; b < 48; b++) begin
            @(posedge sd_clk); #1;
            tx = {tx[46:0], sd_cmd_o};
        end
        @(negedge sd_clk); #1;
        rel_ok = !sd_cmd_oe && sd_cmd_o;
        if (resp_en && card_on) begin
            repeat (delay) @(negedge sd_clk);
            for (int b = 47; b >= 0; b--) begin
                @(negedge sd_clk); #1;
                sd_cmd_i = card_frame[b];
            end
            @(negedge sd_clk); #1;
            sd_cmd_i = 1'b1;
        end
        prev = sd_clk;
        for (int i = 0; i < 3000; i++) begin
            if (resp_valid) begin got = 1'b1; break; end
            @(posedge axi_clk); #1;
            if (sd_clk && !prev) rises++;
            prev = sd_clk;
        end
        if (got) begin st = resp_status; ri = resp_index; rd = resp_data; end
    endtask

    task automatic ack_resp(output logic v_after, output logic r_after);
        resp_ready = 1'b1;
        @(posedge axi_clk); #1;
        resp_ready = 1'b0;
        v_after = resp_valid;
        r_after = cmd_ready;
    endtask

    task automatic test_reset();
        #1 axi_resetn = 1'b0;
        repeat (3) @(posedge axi_clk);
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        n_cmp++; if ({resp_index, resp_data, resp_status} !== 40'h0) begin n_bad++; $display("FAIL rst_resp_fields got %h/%h/%b exp 0", resp_index, resp_data, resp_status); end
        n_cmp++; if ({sd_clk, sd_cmd_o, sd_cmd_oe} !== 3'b010) begin n_bad++; $display("FAIL rst_sd_pins got clk/o/oe %b exp 010", {sd_clk, sd_cmd_o, sd_cmd_oe}); end
        axi_resetn = 1'b1;
        repeat (2) @(posedge axi_clk);
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_cmd_ready got %b exp 1", cmd_ready); end
    endtask

    task automatic test_cmd0();
        logic [47:0] tx; logic s, r, g, va, ra; logic [1:0] st; logic [5:0] ri; logic [31:0] rd; int rs;
        do_cmd(6'd0, 32'h0, 1'b0, 1'b0, 0, 48'h0, tx, s, r, g, st, ri, rd, rs);
        n_cmp++; if (tx !== 48'h40_0000_0000_95) begin n_bad++; $display("FAIL cmd0_tx got %h exp 400000000095", tx); end
        n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL cmd0_release got %b exp 1", r); end
        n_cmp++; if (g !== 1'b1) begin n_bad++; $display("FAIL cmd0_resp_valid got %b exp 1", g); end
        n_cmp++; if ({st, ri, rd} !== 40'h0) begin n_bad++; $display("FAIL cmd0_result got st %b idx %h data %h exp all 0", st, ri, rd); end
        ack_resp(va, ra);
        n_cmp++; if ({va, ra} !== 2'b01) begin n_bad++; $display("FAIL cmd0_ack got valid/ready %b exp 01", {va, ra}); end
    endtask

    task automatic test_cmd8();
        logic [47:0] tx; logic s, r, g, va, ra; logic [1:0] st; logic [5:0] ri; logic [31:0] rd; int rs;
        do_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 5, 48'h08_0000_01AA_13, tx, s, r, g, st, ri, rd, rs);
        n_cmp++; if (tx !== 48'h48_0000_01AA_87) begin n_bad++; $display("FAIL cmd8_tx got %h exp 48000001aa87", tx); end
        n_cmp++; if (g !== 1'b1) begin n_bad++; $display("FAIL cmd8_resp_valid got %b exp 1", g); end
        n_cmp++; if (st !== 2'b00) begin n_bad++; $display("FAIL cmd8_status got %b exp 00", st); end
        n_cmp++; if ({ri, rd} !== {6'd8, 32'h1AA}) begin n_bad++; $display("FAIL cmd8_fields got idx %0d data %h exp 8 1aa", ri, rd); end
        ack_resp(va, ra);
    endtask

    task automatic test_timeout();
        logic [47:0] tx; logic s, r, g, va, ra; logic [1:0] st; logic [5:0] ri; logic [31:0] rd; int rs;
        do_cmd(6'd55, 32'h0, 1'b1, 1'b0, 0, 48'h0, tx, s, r, g, st, ri, rd, rs);
        n_cmp++; if (tx !== mk_frame(1'b1, 6'd55, 32'h0)) begin n_bad++; $display("FAIL cmd55_tx got %h exp %h", tx, mk_frame(1'b1, 6'd55, 32'h0)); end
        n_cmp++; if (st !== 2'b01) begin n_bad++; $display("FAIL timeout_status got %b exp 01", st); end
        n_cmp++; if ({ri, rd} !== 38'h0) begin n_bad++; $display("FAIL timeout_fields got idx %h data %h exp 0", ri, rd); end
        n_cmp++; if (rs !== 64) begin n_bad++; $display("FAIL timeout_rises got %0d exp 64", rs); end
        ack_resp(va, ra);
    endtask

    task automatic test_crc_err();
        logic [47:0] tx, cf; logic s, r, g, va, ra; logic [1:0] st, exp_st; logic [5:0] ri; logic [31:0] rd; int rs;
        cf = 48'h08_0000_01AA_13 ^ 48'h00_0000_0000_10;
`ifdef SDIO_CMD_CRC_CHECK_EN
        exp_st = 2'b10;
`else
        exp_st = 2'b00;
`endif
        do_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 2, cf, tx, s, r, g, st, ri, rd, rs);
        n_cmp++; if (st !== exp_st) begin n_bad++; $display("FAIL crc_err_status got %b exp %b", st, exp_st); end
        n_cmp++; if ({ri, rd} !== {6'd8, 32'h1AA}) begin n_bad++; $display("FAIL crc_err_fields got idx %0d data %h exp 8 1aa", ri, rd); end
        ack_resp(va, ra);
    endtask

    task automatic test_stall();
        logic [47:0] tx; logic s, r, g, va, ra, stable, oe_seen; logic [1:0] st; logic [5:0] ri; logic [31:0] rd; int rs;
        logic [31:0] arg;
        arg = $urandom;
        do_cmd(6'd17, arg, 1'b1, 1'b1, 3, mk_frame(1'b0, 6'd17, arg), tx, s, r, g, st, ri, rd, rs);
        n_cmp++; if ({g, st, ri, rd} !== {1'b1, 2'b00, 6'd17, arg}) begin n_bad++; $display("FAIL stall_result got v %b st %b idx %0d data %h exp 1 00 17 %h", g, st, ri, rd, arg); end
        cmd_valid = 1'b1; cmd_index = 6'h3F; cmd_arg = $urandom; cmd_resp_en = 1'b0;
        stable = 1'b1;
        repeat (20) begin
            @(posedge axi_clk); #1;
            if (!resp_valid || resp_status !== 2'b00 || resp_data !== arg || resp_index !== 6'd17 || cmd_ready || sd_cmd_oe)
                stable = 1'b0;
        end
        cmd_valid = 1'b0;
        n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL stall_hold got stable %b exp 1", stable); end
        ack_resp(va, ra);
        n_cmp++; if ({va, ra} !== 2'b01) begin n_bad++; $display("FAIL stall_ack got valid/ready %b exp 01", {va, ra}); end
        oe_seen = 1'b0;
        repeat (40) begin
            @(posedge axi_clk); #1;
            if (sd_cmd_oe || !cmd_ready) oe_seen = 1'b1;
        end
        n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL stall_ignored_cmd got busy %b exp 0", oe_seen); end
    endtask

    task automatic test_random();
        logic [47:0] tx, cf, exp_tx; logic s, r, g, va, ra, resp_en, card_on, dir, endb;
        logic [1:0] st, exp_st; logic [5:0] ri, idx, ridx, exp_ri; logic [31:0] rd, arg, rarg, exp_rd;
        int rs, corrupt, dly;
        for (int it = 0; it < 8; it++) begin
            idx = 6'($urandom); arg = $urandom; resp_en = 1'($urandom);
            card_on = ($urandom_range(0, 4) != 0); corrupt = $urandom_range(0, 3); dly = $urandom_range(0, 30);
            ridx = 6'($urandom); rarg = $urandom;
            dir = (corrupt == 2); endb = (corrupt != 3);
            cf = mk_frame(dir, ridx, rarg);
            cf[0] = endb;
            if (corrupt == 1) cf[1 + $urandom_range(0, 6)] ^= 1'b1;
            exp_tx = mk_frame(1'b1, idx, arg);
            exp_st = 2'b00; exp_ri = '0; exp_rd = '0;
            if (resp_en && !card_on) exp_st = 2'b01;
            if (resp_en && card_on) begin
                exp_ri = ridx; exp_rd = rarg;
`ifdef SDIO_CMD_CRC_CHECK_EN
                if (corrupt != 0) exp_st = 2'b10;
`endif
            end
            do_cmd(idx, arg, resp_en, card_on, dly, cf, tx, s, r, g, st, ri, rd, rs);
            n_cmp++; if (tx !== exp_tx) begin n_bad++; $display("FAIL rnd%0d_tx got %h exp %h", it, tx, exp_tx); end
            n_cmp++; if ({g, st} !== {1'b1, exp_st}) begin n_bad++; $display("FAIL rnd%0d_status got v %b st %b exp 1 %b", it, g, st, exp_st); end
            n_cmp++; if ({ri, rd} !== {exp_ri, exp_rd}) begin n_bad++; $display("FAIL rnd%0d_fields got %h/%h exp %h/%h", it, ri, rd, exp_ri, exp_rd); end
            ack_resp(va, ra);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [47:0] tx, exp_tx; logic [19:0] part; logic s, r, g, va, ra, started; logic [1:0] st; logic [5:0] ri; logic [31:0] rd; int rs;
        logic [31:0] arg;
        arg = $urandom;
        exp_tx = mk_frame(1'b1, 6'd24, arg);
        for (int i = 0; i < 100 && !cmd_ready; i++) begin @(posedge axi_clk); #1; end
        cmd_index = 6'd24; cmd_arg = arg; cmd_resp_en = 1'b1; cmd_valid = 1'b1;
        @(posedge axi_clk); #1;
        cmd_valid = 1'b0;
        started = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge axi_clk); #1;
            if (sd_cmd_oe) begin started = 1'b1; break; end
        end
        part = '0;
        for (int b = 0; b < 20; b++) begin
            @(posedge sd_clk); #1;
            part = {part[18:0], sd_cmd_o};
        end
        n_cmp++; if ({started, part} !== {1'b1, exp_tx[47:28]}) begin n_bad++; $display("FAIL midrst_partial got %b/%h exp 1/%h", started, part, exp_tx[47:28]); end
        #2 axi_resetn = 1'b0;
        #1;
        n_cmp++; if ({sd_cmd_oe, sd_cmd_o, resp_valid} !== 3'b010) begin n_bad++; $display("FAIL midrst_pins got oe/o/valid %b exp 010", {sd_cmd_oe, sd_cmd_o, resp_valid}); end
        repeat (3) @(posedge axi_clk);
        #1 axi_resetn = 1'b1;
        do_cmd(6'd0, 32'h0, 1'b0, 1'b0, 0, 48'h0, tx, s, r, g, st, ri, rd, rs);
        n_cmp++; if (tx !== 48'h40_0000_0000_95) begin n_bad++; $display("FAIL midrst_next_tx got %h exp 400000000095", tx); end
        n_cmp++; if ({g, st, ri, rd} !== {1'b1, 40'h0}) begin n_bad++; $display("FAIL midrst_next_result got v %b st %b exp 1 00", g, st); end
        ack_resp(va, ra);
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_timeout();
        test_crc_err();
        test_stall();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        n_bad++;
        $display("FAIL watchdog expired at time %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
